cpc_rom_bus_master: RTL and testbench
=====================================

CPC_ROM_BUS_MASTER -- requirements
Module: cpc_rom_bus_master

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of wait-state cycles before a cycle is aborted (used only when CPC_WAIT_TIMEOUT_EN is defined).
REQ-002 CLK  in  1  single clock; all logic is on the rising edge.
REQ-003 RESET_B  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  request strobe.
REQ-005 req_ready  out  1  the block accepts a request when this is high.
REQ-006 req_type  in  1  0 = ROM-select I/O write, 1 = memory read.
REQ-007 req_addr  in  16  address of the bus cycle.
REQ-008 req_data  in  8  write data for ROM-select cycles.
REQ-009 lower_rom_en, upper_rom_en  in  1 each  enable ROMEN_B decode for the 0000-3FFF and C000-FFFF regions.
REQ-010 A  out  16  address bus.
REQ-011 D_out  out  8  data driven onto the bus.
REQ-012 D_oe  out  1  enables D_out onto the bus.
REQ-013 D_in  in  8  data sampled from the bus.
REQ-014 MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, ROMEN_B  out  1 each  active-low bus strobes.
REQ-015 READY  in  1  wait input; low inserts wait states.
REQ-016 ROMDIS  in  1  an expansion board is overriding the internal ROM.
REQ-017 rsp_valid  out  1  one-cycle completion pulse.
REQ-018 rsp_data  out  8  read data.
REQ-019 rsp_romdis  out  1  ROMDIS value sampled at data capture.
REQ-020 rsp_err  out  1  the cycle was aborted on timeout.

Function
REQ-021 The FSM SHALL have the states IDLE, T1, T2, TW and T3; req_ready SHALL be 1 only in IDLE.
REQ-022 When req_valid and req_ready are both high, the block SHALL latch the request and enter T1 on the next edge.
REQ-023 In T1, A SHALL equal req_addr, and all strobes SHALL assert together with A for the whole cycle.
- Memory read: MREQ_B=0, RD_B=0, M1_B=1.
- ROMEN_B=0 iff (addr[15:14]==11 and upper_rom_en) or (addr[15:14]==00 and lower_rom_en).
REQ-024 For an I/O write, T1 SHALL drive IOREQ_B=0, WR_B=0, D_out=req_data and D_oe=1; ROMEN_B and MREQ_B SHALL stay high.
REQ-025 T2 → TW if READY==0, otherwise T3 for reads.
REQ-026 An I/O write SHALL always pass through exactly one forced TW (the Z80 automatic wait), plus one extra TW per cycle in which READY is low.
REQ-027 TW → T3 when READY==1.
REQ-028 In T3, a read SHALL capture D_in into rsp_data and ROMDIS into rsp_romdis.
REQ-029 On exit from T3, all strobes SHALL deassert, D_oe SHALL be 0, rsp_valid SHALL pulse in the IDLE-entry cycle, and req_ready SHALL go high in that same cycle.
REQ-030 Read latency with READY high SHALL be 4 cycles from acceptance to rsp_valid; I/O write latency SHALL be 5 cycles.
REQ-031 rsp_data SHALL hold its value until the next read completes; rsp_data for a write SHALL be unchanged.
REQ-032 req_valid during a non-IDLE state SHALL be ignored; no queueing.

Reset
REQ-033 While RESET_B is low, the block SHALL be in IDLE with:
- A=0000, D_out=00, D_oe=0;
- all strobes and ROMEN_B = 1;
- rsp_valid=0, rsp_data=00, rsp_romdis=0, rsp_err=0.
REQ-034 Reset asserted mid-cycle SHALL abort that cycle immediately with no rsp_valid.

Configuration
REQ-035 With CPC_WAIT_TIMEOUT_EN defined:
- A 5-bit counter SHALL count TW cycles.
- Once the counter reaches TIMEOUT_CYCLES, the block SHALL deassert the strobes, return to IDLE, and pulse rsp_valid with rsp_err=1.
REQ-036 Without CPC_WAIT_TIMEOUT_EN, TW SHALL wait indefinitely and rsp_err SHALL be constant 0.

Structure
REQ-037 The shared package cpc_bus_pkg SHALL hold:
- the FSM state enum;
- the REQ_IOWR/REQ_MEMRD constants;
- the ROM-select port address constant 16'hDF00 (A13 low);
- the region constants.
REQ-038 The optional timeout counter SHALL be the sub-module cpc_wait_timer.

Verification
REQ-039 Write, READY=1, addr DF00, data 05 -> IOREQ_B/WR_B low for 4 cycles, D=05, rsp_valid at cycle 5, ROMEN_B high throughout.
REQ-040 Read C123, upper_rom_en=1, D_in=A5, ROMDIS=0 -> ROMEN_B low for 3 cycles, rsp_data=A5, rsp_romdis=0, rsp_valid at cycle 4.
REQ-041 Read 4000 with D_in=3C and READY low 3 cycles from T2 -> ROMEN_B high throughout, 3 TW cycles, rsp_valid at cycle 7, rsp_data=3C.
REQ-042 Read C000 with ROMDIS=1, D_in=FF -> rsp_romdis=1.
REQ-043 RESET_B low during TW -> all outputs take their reset values immediately, no rsp_valid, req_ready=1 after release.
REQ-044 CPC_WAIT_TIMEOUT_EN defined, READY stuck low -> after 16 TW cycles, rsp_valid=1 and rsp_err=1 with strobes high.

Source files
------------

// File: rtl/cpc_bus_pkg.sv
// Shared types and constants for the CPC ROM bus master.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cpc_bus_pkg;

   // Z80 machine-cycle states driven by the bus master
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_T1   = 3'd1,
      ST_T2   = 3'd2,
      ST_TW   = 3'd3,
      ST_T3   = 3'd4
   } bus_state_e;

   // Request kinds carried on req_type
   localparam logic REQ_IOWR  = 1'b0;
   localparam logic REQ_MEMRD = 1'b1;

   // ROM-select I/O port; only A13 low is decoded by the gate array
   localparam logic [15:0] ROM_SEL_PORT = 16'hDF00;

   // A[15:14] values of the two internal ROM windows
   localparam logic [1:0] REGION_LOWER = 2'b00;
   localparam logic [1:0] REGION_UPPER = 2'b11;

   // Latched request
   typedef struct packed {
      logic        rtype;
      logic [15:0] addr;
      logic [7:0]  dat;
   } req_t;

   // True when addr falls in an enabled internal ROM window
   function automatic logic rom_region_hit(input logic [15:0] addr,
                                           input logic        lower_en,
                                           input logic        upper_en);
      return ((addr[15:14] == REGION_UPPER) && upper_en) ||
             ((addr[15:14] == REGION_LOWER) && lower_en);
   endfunction

endpackage

// File: rtl/cpc_rom_bus_master_if.sv
// Z80-style CPC bus between the master and memory/IO/expansion side.
// Latency: n/a (wires only).
// Backpressure: READY low from the slave stretches the bus cycle.
interface cpc_rom_bus_master_if;

   logic [15:0] A;
   logic [7:0]  D_out;
   logic        D_oe;
   logic [7:0]  D_in;
   logic        MREQ_B;
   logic        IOREQ_B;
   logic        RD_B;
   logic        WR_B;
   logic        M1_B;
   logic        ROMEN_B;
   logic        READY;
   logic        ROMDIS;

   modport master (
      output A, D_out, D_oe, MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, ROMEN_B,
      input  D_in, READY, ROMDIS
   );

   modport slave (
      input  A, D_out, D_oe, MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, ROMEN_B,
      output D_in, READY, ROMDIS
   );

endinterface

// File: rtl/cpc_wait_timer.sv
// Counts consecutive wait-state cycles and flags the last allowed one.
// Latency: expired_o is combinational on the current count (same cycle).
// Backpressure: none; the count clears whenever count_en_i drops.
module cpc_wait_timer #(
   parameter int TIMEOUT_CYCLES = 16   // must fit the 5-bit counter (1..31)
) (
   input  logic CLK,
   input  logic RESET_B,
   input  logic count_en_i,
   output logic expired_o
);

   logic [4:0] cnt_q;
   logic [4:0] cnt_d;

   // Count TW cycles while enabled, restart from zero otherwise
   always_comb begin
      cnt_d = 5'd0;
      if (count_en_i) begin
         cnt_d = cnt_q + 5'd1;
      end
   end

   // Counter register
   always_ff @(posedge CLK or negedge RESET_B) begin
      if (!RESET_B) begin
         cnt_q <= 5'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The current TW cycle is the TIMEOUT_CYCLES-th one: the count reaches the
   // limit at this edge, so the master gives up instead of waiting again.
   assign expired_o = count_en_i && (cnt_q == 5'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cpc_rom_bus_master.sv
// Runs one Z80 bus cycle (memory read or ROM-select I/O write) per accepted request.
// Latency: read 4 cycles, I/O write 5 cycles from acceptance to rsp_valid, +1 per wait state.
// Backpressure: req_ready only in IDLE, no queueing; READY low inserts TW states.
// Optional: define CPC_WAIT_TIMEOUT_EN to abort a cycle after TIMEOUT_CYCLES wait states.
module cpc_rom_bus_master
   import cpc_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                        CLK,
   input  logic                        RESET_B,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic                        req_type,
   input  logic [15:0]                 req_addr,
   input  logic [7:0]                  req_data,
   input  logic                        lower_rom_en,
   input  logic                        upper_rom_en,
   cpc_rom_bus_master_if.master        bus,
   output logic                        rsp_valid,
   output logic [7:0]                  rsp_data,
   output logic                        rsp_romdis,
   output logic                        rsp_err
);

   bus_state_e state_q;
   bus_state_e state_d;
   req_t       req_q;
   req_t       req_d;
   logic       rsp_valid_q;
   logic       rsp_valid_d;
   logic [7:0] rsp_data_q;
   logic [7:0] rsp_data_d;
   logic       rsp_romdis_q;
   logic       rsp_romdis_d;
   logic       rsp_err_q;
   logic       rsp_err_d;
   logic       tw_active;
   logic       tmo_expired;

   assign tw_active = (state_q == ST_TW);

`ifdef CPC_WAIT_TIMEOUT_EN
   cpc_wait_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wait_timer (
      .CLK        (CLK),
      .RESET_B    (RESET_B),
      .count_en_i (tw_active),
      .expired_o  (tmo_expired)
   );
`else
   // Without the timer a TW state waits for READY forever
   logic tmo_cfg_unused;
   assign tmo_cfg_unused = tw_active & (TIMEOUT_CYCLES != 0);
   assign tmo_expired    = 1'b0;
`endif

   // Next-state logic: request latch, T-state sequencing and response capture
   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      rsp_valid_d  = 1'b0;
      rsp_err_d    = 1'b0;
      rsp_data_d   = rsp_data_q;
      rsp_romdis_d = rsp_romdis_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               req_d   = '{rtype: req_type, addr: req_addr, dat: req_data};
               state_d = ST_T1;
            end
         end
         ST_T1: begin
            state_d = ST_T2;
         end
         ST_T2: begin
            // I/O cycles always get the automatic Z80 wait state
            if ((req_q.rtype == REQ_IOWR) || !bus.READY) begin
               state_d = ST_TW;
            end else begin
               state_d = ST_T3;
            end
         end
         ST_TW: begin
            // A slave releasing READY on the last allowed TW still completes
            if (bus.READY) begin
               state_d = ST_T3;
            end else if (tmo_expired) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
            end
         end
         ST_T3: begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b1;
            if (req_q.rtype == REQ_MEMRD) begin
               rsp_data_d   = bus.D_in;
               rsp_romdis_d = bus.ROMDIS;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, request and response registers
   always_ff @(posedge CLK or negedge RESET_B) begin
      if (!RESET_B) begin
         state_q      <= ST_IDLE;
         req_q        <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= 8'h00;
         rsp_romdis_q <= 1'b0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         rsp_romdis_q <= rsp_romdis_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   // Bus strobes decoded from the state so reset releases them immediately
   always_comb begin
      bus.A       = 16'h0000;
      bus.D_out   = 8'h00;
      bus.D_oe    = 1'b0;
      bus.MREQ_B  = 1'b1;
      bus.IOREQ_B = 1'b1;
      bus.RD_B    = 1'b1;
      bus.WR_B    = 1'b1;
      bus.M1_B    = 1'b1;
      bus.ROMEN_B = 1'b1;
      if (state_q != ST_IDLE) begin
         bus.A = req_q.addr;
         if (req_q.rtype == REQ_MEMRD) begin
            bus.MREQ_B  = 1'b0;
            bus.RD_B    = 1'b0;
            bus.ROMEN_B = !rom_region_hit(req_q.addr, lower_rom_en, upper_rom_en);
         end else begin
            bus.IOREQ_B = 1'b0;
            bus.WR_B    = 1'b0;
            bus.D_out   = req_q.dat;
            bus.D_oe    = 1'b1;
         end
      end
   end

   assign req_ready  = (state_q == ST_IDLE);
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_romdis = rsp_romdis_q;
   assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_cpc_rom_bus_master.sv
// Randomized and directed bench for cpc_rom_bus_master against a cycle-count model.
// Latency: model predicts each bus cycle's length from type and READY pattern.
// Backpressure: READY low windows and ignored mid-cycle requests are exercised.
module tb_cpc_rom_bus_master;

   localparam int TMO = 16;

   logic        CLK = 1'b0;
   logic        RESET_B = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_type = 1'b0;
   logic [15:0] req_addr = 16'h0;
   logic [7:0]  req_data = 8'h0;
   logic        lower_rom_en = 1'b0;
   logic        upper_rom_en = 1'b0;
   logic        req_ready;
   logic        rsp_valid;
   logic [7:0]  rsp_data;
   logic        rsp_romdis;
   logic        rsp_err;

   int          n_vec = 0;
   int          n_err = 0;
   logic [7:0]  m_rsp_data;
   logic        m_romdis;

   cpc_rom_bus_master_if bus ();

   cpc_rom_bus_master #(.TIMEOUT_CYCLES(TMO)) dut (
      .CLK          (CLK),
      .RESET_B      (RESET_B),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_type     (req_type),
      .req_addr     (req_addr),
      .req_data     (req_data),
      .lower_rom_en (lower_rom_en),
      .upper_rom_en (upper_rom_en),
      .bus          (bus),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .rsp_romdis   (rsp_romdis),
      .rsp_err      (rsp_err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // {A, MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, ROMEN_B, D_oe, D_out, req_ready, rsp_valid}
   function automatic logic [32:0] obs_vec();
      return {bus.A, bus.MREQ_B, bus.IOREQ_B, bus.RD_B, bus.WR_B, bus.M1_B,
              bus.ROMEN_B, bus.D_oe, bus.D_out, req_ready, rsp_valid};
   endfunction

   function automatic logic [32:0] idle_vec(input logic v);
      return {16'h0000, 6'b111111, 1'b0, 8'h00, 1'b1, v};
   endfunction

   // typ 1 = memory read (MREQ/RD low), 0 = I/O write (IOREQ/WR low, data driven)
   function automatic logic [32:0] busy_vec(input logic typ, input logic [15:0] addr,
                                            input logic [7:0] data, input logic romen_b);
      return {addr, ~typ, typ, ~typ, typ, 1'b1, romen_b, ~typ,
              (typ ? 8'h00 : data), 1'b0, 1'b0};
   endfunction

   // One request. stall = READY-low cycles: from T2 for reads, from the first TW
   // for writes. abort_at > 0 pulls reset at that cycle after acceptance.
   task automatic run_txn(input logic typ, input logic [15:0] addr, input logic [7:0] data,
                          input int stall, input logic [7:0] din, input logic romdis,
                          input int abort_at);
      int   tw;
      int   lat;
      int   t3;
      int   rdy_lo;
      logic tmo;
      logic romen_b;
      tw  = typ ? stall : stall + 1;
      tmo = 1'b0;
`ifdef CPC_WAIT_TIMEOUT_EN
      if (tw > TMO) begin
         tw  = TMO;
         tmo = 1'b1;
      end
`endif
      lat     = tmo ? 3 + tw : 4 + tw;
      t3      = tmo ? -1 : lat - 1;
      rdy_lo  = typ ? 2 : 3;
      romen_b = !(typ && ((addr[15:14] == 2'b11 && upper_rom_en) ||
                          (addr[15:14] == 2'b00 && lower_rom_en)));
      @(negedge CLK);
      chk("idle", obs_vec(), idle_vec(1'b0));
      req_valid = 1'b1;
      req_type  = typ;
      req_addr  = addr;
      req_data  = data;
      bus.READY = 1'b1;
      for (int k = 1; k <= lat; k++) begin
         @(negedge CLK);
         if (k < lat && $urandom_range(0, 1) == 1) begin
            req_valid = 1'b1;
            req_type  = 1'($urandom_range(0, 1));
            req_addr  = 16'($urandom);
            req_data  = 8'($urandom);
         end else begin
            req_valid = 1'b0;
         end
         bus.READY  = !(k >= rdy_lo && k < rdy_lo + stall);
         bus.D_in   = (k == t3) ? din : 8'($urandom);
         bus.ROMDIS = (k == t3) ? romdis : 1'($urandom_range(0, 1));
         if (k == abort_at) begin
            RESET_B   = 1'b0;
            req_valid = 1'b0;
            #1;
            chk("rst_bus", obs_vec(), idle_vec(1'b0));
            chk("rst_rsp", {rsp_data, rsp_romdis, rsp_err}, 10'h000);
            m_rsp_data = 8'h00;
            m_romdis   = 1'b0;
            for (int r = 0; r < 2; r++) begin
               @(negedge CLK);
               chk("rst_hold", obs_vec(), idle_vec(1'b0));
            end
            RESET_B   = 1'b1;
            bus.READY = 1'b1;
            @(negedge CLK);
            chk("post_rst", obs_vec(), idle_vec(1'b0));
            chk("post_rst_data", rsp_data, m_rsp_data);
            return;
         end
         if (k < lat) begin
            chk("busy", obs_vec(), busy_vec(typ, addr, data, romen_b));
         end else begin
            if (typ && !tmo) begin
               m_rsp_data = din;
               m_romdis   = romdis;
            end
            chk("done", obs_vec(), idle_vec(1'b1));
            chk("rsp_data", rsp_data, m_rsp_data);
            if (typ && !tmo) chk("rsp_romdis", rsp_romdis, m_romdis);
            chk("rsp_err", rsp_err, tmo);
         end
      end
      bus.READY = 1'b1;
      req_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bus.READY  = 1'b1;
      bus.D_in   = 8'h00;
      bus.ROMDIS = 1'b0;
      m_rsp_data = 8'h00;
      m_romdis   = 1'b0;
      RESET_B    = 1'b0;
      repeat (3) @(negedge CLK);
      chk("reset_bus", obs_vec(), idle_vec(1'b0));
      chk("reset_rsp", {rsp_data, rsp_romdis, rsp_err}, 10'h000);
      RESET_B = 1'b1;

      // ROM-select write, no wait: IOREQ/WR low 4 cycles, rsp at 5
      lower_rom_en = 1'b1; upper_rom_en = 1'b1;
      run_txn(1'b0, 16'hDF00, 8'h05, 0, 8'h00, 1'b0, 0);
      // upper ROM read
      lower_rom_en = 1'b0; upper_rom_en = 1'b1;
      run_txn(1'b1, 16'hC123, 8'h00, 0, 8'hA5, 1'b0, 0);
      // RAM read with three wait states
      lower_rom_en = 1'b1; upper_rom_en = 1'b1;
      run_txn(1'b1, 16'h4000, 8'h00, 3, 8'h3C, 1'b0, 0);
      // expansion ROM override
      run_txn(1'b1, 16'hC000, 8'h00, 0, 8'hFF, 1'b1, 0);
      // write with extra waits must leave rsp_data at FF
      run_txn(1'b0, 16'hDF00, 8'h07, 2, 8'h00, 1'b0, 0);
      // lower ROM window on, then off
      lower_rom_en = 1'b1; upper_rom_en = 1'b0;
      run_txn(1'b1, 16'h0123, 8'h00, 1, 8'h11, 1'b0, 0);
      lower_rom_en = 1'b0;
      run_txn(1'b1, 16'h0123, 8'h00, 0, 8'h22, 1'b1, 0);
      // reset during TW
      run_txn(1'b1, 16'h8000, 8'h00, 10, 8'h99, 1'b0, 4);
`ifdef CPC_WAIT_TIMEOUT_EN
      // READY stuck low: abort after TMO wait states
      upper_rom_en = 1'b1;
      run_txn(1'b1, 16'hC000, 8'h00, TMO + 14, 8'h44, 1'b0, 0);
      run_txn(1'b0, 16'hDF00, 8'h03, TMO + 9, 8'h00, 1'b0, 0);
`else
      // long stall beyond TMO still completes normally
      upper_rom_en = 1'b1;
      run_txn(1'b1, 16'hC000, 8'h00, TMO + 4, 8'h44, 1'b0, 0);
`endif
      for (int i = 0; i < 40; i++) begin
         lower_rom_en = 1'($urandom_range(0, 1));
         upper_rom_en = 1'($urandom_range(0, 1));
         run_txn(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
                 int'($urandom_range(0, 4)), 8'($urandom), 1'($urandom_range(0, 1)), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
